// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the MAC-array control sequencer.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadW,
    StStream,
    StDone
  } seq_state_t;

  localparam int unsigned DefaultN  = 4;
  localparam int unsigned DefaultKw = 16;

  // Number of STREAM cycles for K vectors through an n x n array (no stalls).
  function automatic int unsigned stream_len(input int unsigned k, input int unsigned n);
    return k + 2 * n - 1;
  endfunction

endpackage

// File: rtl/mac_seq_window.sv
// Window decode: high while offset <= t < offset + k.
module mac_seq_window #(
  parameter int unsigned KW = 16,
  parameter int unsigned CW = KW + 1
) (
  input  logic [CW-1:0] t_i,
  input  logic [CW-1:0] offset_i,
  input  logic [KW-1:0] k_i,
  output logic          in_win_o
);
  localparam int unsigned HW = CW + 1;

  logic [HW-1:0] hi;

  // One extra bit so offset + k never wraps.
  assign hi       = {1'b0, offset_i} + HW'(k_i);
  assign in_win_o = (t_i >= offset_i) && ({1'b0, t_i} < hi);

endmodule

// File: rtl/mac_array_sequencer.sv
// Control sequencer for an N x N systolic MAC array: weight load, skewed feature
// streaming and per-column result flags. Every output is a flop.
module mac_array_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned N  = DefaultN,
  parameter int unsigned KW = DefaultKw
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        num_vec,
  input  logic                 abort,
  input  logic                 fm_valid,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         wen,
  output logic [$clog2(N)-1:0] w_row,
  output logic                 arr_en,
  output logic [N-1:0]         fm_en,
  output logic [KW-1:0]        fm_idx,
  output logic [N-1:0]         res_valid
);
  localparam int unsigned RW = $clog2(N);
  localparam int unsigned CW = KW + 1;

  seq_state_t    state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] t_last, inj_end;
  logic          active_d;
  logic [N-1:0]  fm_win, res_win;

  assign t_last  = CW'(stream_len(32'(k_q), N) - 32'd1);
  assign inj_end = CW'(k_q) + CW'(N - 1);

  // t_q doubles as the row counter in StLoadW. In StStream, arr_en is the
  // registered "this cycle advanced" flag, so t only moves on active cycles.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          t_d = '0;
          if (num_vec != '0) begin
            k_d     = num_vec;
            state_d = StLoadW;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoadW: begin
        if (t_q == CW'(N - 1)) begin
          t_d     = '0;
          state_d = StStream;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      StStream: begin
        if (arr_en) begin
          if (t_q == t_last) begin
            t_d     = '0;
            state_d = StDone;
          end else begin
            t_d = t_q + CW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      t_d     = '0;
    end
  end

  // fm_valid is sampled on the edge that opens the cycle it governs; outside the
  // injection window the drain runs regardless.
  assign active_d = (state_d == StStream) && (fm_valid || (t_d >= inj_end));

  for (genvar i = 0; i < N; i++) begin : g_win
    mac_seq_window #(
      .KW(KW),
      .CW(CW)
    ) u_fm_win (
      .t_i     (t_d),
      .offset_i(CW'(i)),
      .k_i     (k_q),
      .in_win_o(fm_win[i])
    );
    mac_seq_window #(
      .KW(KW),
      .CW(CW)
    ) u_res_win (
      .t_i     (t_d),
      .offset_i(CW'(N + i)),
      .k_i     (k_q),
      .in_win_o(res_win[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      k_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wen       <= '0;
      w_row     <= '0;
      arr_en    <= 1'b0;
      fm_en     <= '0;
      fm_idx    <= '0;
      res_valid <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      k_q       <= k_d;
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
      wen       <= (state_d == StLoadW) ? (N'(1) << t_d[RW-1:0]) : '0;
      w_row     <= (state_d == StLoadW) ? t_d[RW-1:0] : '0;
      arr_en    <= active_d;
      fm_en     <= active_d ? fm_win : '0;
      res_valid <= active_d ? res_win : '0;
      if (state_d == StStream) begin
        fm_idx <= (t_d < CW'(k_q)) ? t_d[KW-1:0] : (k_q - KW'(1));
      end else begin
        fm_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer with a per-cycle expected-output scoreboard.
module tb_mac_array_sequencer;
  localparam int unsigned N  = 4;
  localparam int unsigned KW = 16;
  localparam int unsigned RW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] num_vec = '0;
  logic          abort = 1'b0;
  logic          fm_valid = 1'b1;
  logic          busy, done, arr_en;
  logic [N-1:0]  wen, fm_en, res_valid;
  logic [RW-1:0] w_row;
  logic [KW-1:0] fm_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [N-1:0]  wen;
    logic [RW-1:0] w_row;
    logic          arr_en;
    logic [N-1:0]  fm_en;
    logic [KW-1:0] fm_idx;
    logic [N-1:0]  res_valid;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mac_array_sequencer #(
    .N (N),
    .KW(KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_vec  (num_vec),
    .abort    (abort),
    .fm_valid (fm_valid),
    .busy     (busy),
    .done     (done),
    .wen      (wen),
    .w_row    (w_row),
    .arr_en   (arr_en),
    .fm_en    (fm_en),
    .fm_idx   (fm_idx),
    .res_valid(res_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, " busy"},      32'(busy),      32'(e.busy));
    chk({tag, " done"},      32'(done),      32'(e.done));
    chk({tag, " wen"},       32'(wen),       32'(e.wen));
    chk({tag, " w_row"},     32'(w_row),     32'(e.w_row));
    chk({tag, " arr_en"},    32'(arr_en),    32'(e.arr_en));
    chk({tag, " fm_en"},     32'(fm_en),     32'(e.fm_en));
    chk({tag, " fm_idx"},    32'(fm_idx),    32'(e.fm_idx));
    chk({tag, " res_valid"}, 32'(res_valid), 32'(e.res_valid));
  endtask

  // Expected waveform for cycles 1..ncyc; cycle 0 is the cycle whose start is accepted.
  task automatic push_model(input int k, input int stall_lo, input int stall_hi,
                            input int abort_cyc, input int ncyc);
    int   ph;
    int   r;
    int   t;
    bit   act;
    exp_t e;
    ph = (k == 0) ? 3 : 1;
    r  = 0;
    t  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (abort_cyc >= 0 && c > abort_cyc) ph = 0;
      e   = '0;
      act = 1'b0;
      case (ph)
        1: begin
          e.busy  = 1'b1;
          e.wen   = N'(1 << r);
          e.w_row = RW'(r);
        end
        2: begin
          e.busy   = 1'b1;
          act      = !(c >= stall_lo && c <= stall_hi) || (t >= k + int'(N) - 1);
          e.fm_idx = KW'((t < k) ? t : k - 1);
          if (act) begin
            e.arr_en = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
              e.fm_en[i]     = (i <= t) && (t < i + k);
              e.res_valid[i] = (int'(N) + i <= t) && (t < int'(N) + i + k);
            end
          end
        end
        3: begin
          e.busy = 1'b1;
          e.done = 1'b1;
        end
        default: ;
      endcase
      sb.push_back(e);
      case (ph)
        1: begin
          if (r == int'(N) - 1) begin
            ph = 2;
            t  = 0;
          end else begin
            r++;
          end
        end
        2: if (act) begin
          if (t == k + 2 * int'(N) - 2) ph = 3;
          else t++;
        end
        3: ph = 0;
        default: ;
      endcase
    end
  endtask

  // start2/abort are given as the cycle in which they are presented; fm_valid for
  // cycle c is presented on the edge that opens cycle c.
  task automatic run(input string tag, input int k, input int stall_lo, input int stall_hi,
                     input int start2, input int abort_cyc, input int ncyc, input int exp_done);
    int done_cyc;
    done_cyc = -1;
    push_model(k, stall_lo, stall_hi, abort_cyc, ncyc);
    num_vec = KW'(k);
    for (int c = 1; c <= ncyc; c++) begin
      start    = (c == 1) || (c - 1 == start2);
      abort    = (c - 1 == abort_cyc);
      fm_valid = !(c >= stall_lo && c <= stall_hi);
      @(posedge clk);
      #1;
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      pop_check($sformatf("%s c%0d", tag, c));
    end
    start    = 1'b0;
    abort    = 1'b0;
    fm_valid = 1'b1;
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    // Reset held with start asserted: everything stays quiet.
    rst   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('0);
      @(posedge clk);
      #1;
      pop_check($sformatf("reset %0d", i));
    end
    rst   = 1'b1;
    start = 1'b0;
    sb.push_back('0);
    @(posedge clk);
    #1;
    pop_check("idle");

    run("nominal",   3, 0, -1, -1, -1, 16, 15);
    run("b2b",       3, 0, -1, -1, -1, 16, 15);
    run("stall",     3, 6, 7, -1, -1, 18, 17);
    run("drainstall", 3, 12, 14, -1, -1, 16, 15);
    run("zero",      0, 0, -1, -1, -1, 3, 1);
    run("abort",     3, 0, -1, 5, 7, 10, -1);
    run("k1",        1, 0, -1, -1, -1, 14, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_array_sequencer.md
# mac_array_sequencer

Control sequencer for an N×N systolic array of MAC units. On `start` it loads one weight row per cycle into the array through the per-row weight-write enables, streams `num_vec` feature vectors with the row-to-row skew the array requires, and flags each accumulated column result as it leaves the bottom edge. It sits between the top-level command path and the MAC array plus its feature and weight buffers. It generates control only; no data passes through it.

## Interface
- `N`, default 4: array dimension, giving rows and columns. Legal range is 2..16.
- `KW`, default 16: width of the vector count.
- `clk`  in  1: the only clock. Everything updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1: command pulse. Accepted only in IDLE.
- `num_vec`  in  KW: feature-vector count K. Latched when `start` is accepted.
- `abort`  in  1: synchronous cancel.
- `fm_valid`  in  1: the feature buffer has the current vector available.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `wen`  out  N: one-hot weight-write enable, one bit per array row. Drives each row's WEn.
- `w_row`  out  $clog2(N): weight-buffer row address.
- `arr_en`  out  1: clock enable for the array. Deasserted, the MACs hold their state.
- `fm_en`  out  N: per-row feature injection enable, skewed.
- `fm_idx`  out  KW: index of the vector currently entering row 0.
- `res_valid`  out  N: per-column flag that the result at the bottom edge is valid.

## Operation
- **States:** IDLE, LOAD_W, STREAM, DONE. All outputs are registered.
- **Reset:** when `rst`=0, the block goes to IDLE and every output is 0, including `fm_idx` and `w_row`.
- **IDLE:**
  - `start`=1 with `num_vec`≠0: latch K and go to LOAD_W.
  - `start`=1 with `num_vec`=0: go directly to DONE. No `wen` is asserted.
- **LOAD_W:** runs for N cycles. In cycle r (0..N-1), `wen` = 1<<r and `w_row` = r, with `arr_en`=0. It then goes to STREAM with the cycle counter t = 0. Loading weights never stalls.
- **STREAM:** counter t runs from 0 to K+2N-2. With `fm_valid`=1:
  - `arr_en`=1.
  - `fm_en[i]` = (i ≤ t < i+K).
  - `res_valid[c]` = (N+c ≤ t < N+c+K).
  - `fm_idx` = t while t < K, and holds K-1 afterwards.
  - t increments.
- **Stall in STREAM:** `fm_valid`=0 while t < K+N-1, which is the injection window. Then t freezes and `arr_en`, `fm_en` and `res_valid` are all 0. Once t ≥ K+N-1, `fm_valid` is ignored and the drain proceeds.
- **STREAM exit:** after t = K+2N-2, go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Busy behaviour:** `start` is ignored whenever `busy`=1.
- **`abort`:** takes effect in any non-IDLE state. Next cycle the block is in IDLE with all outputs 0 and no `done` pulse.
  - `abort` and `start` together in IDLE: `abort` wins and `start` is dropped.
- **`rst` during operation:** same as `abort`.
- **Counter width:** the counter t is KW+1 bits, so the maximum K plus 2N never wraps.

## Timing
- Take the cycle that accepts `start` as cycle 0, with no stalls:
  - `wen` is active in cycles 1..N.
  - STREAM occupies cycles N+1..3N+K-1.
  - `done` is high in cycle 3N+K.
- **First result:** `res_valid[0]` first rises in cycle 2N+1.
- **Last result:** `res_valid[N-1]` last falls after cycle 3N+K-1.
- **Stalls:** each stall cycle inside the injection window adds exactly one cycle to `done`.
- **Back-to-back commands:** `busy` falls in the cycle after `done`, so the earliest next `start` is accepted one cycle after `done`.

## Structure
- **Package `mac_seq_pkg`:**
  - state enum `seq_state_t` with IDLE, LOAD_W, STREAM, DONE;
  - default `N` and `KW` constants;
  - a function returning the STREAM length, K+2N-1.
- **Sub-module `mac_seq_window`:** combinational. Takes t, an offset and K and returns the in-window bit. It is instantiated 2N times:
  - N times for `fm_en`, with offset i;
  - N times for `res_valid`, with offset N+c.
- **Top:** the FSM, the t counter and the output registers.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `start`=1. All outputs stay 0 and `busy`=0.
- **Nominal run:** N=4, K=3, `fm_valid`=1, `start` in cycle 0.
  - `wen` is 0001, 0010, 0100, 1000 in cycles 1..4.
  - `fm_en[3]` is high in cycles 8..10.
  - `res_valid[0]` is high in cycles 9..11 and `res_valid[3]` in cycles 12..14.
  - `done` is high in cycle 15.
- **Stall:** as the nominal run, but with `fm_valid`=0 in cycles 6..7. `done` moves to cycle 17, and `arr_en`, `fm_en` and `res_valid` are all 0 in cycles 6..7.
- **Zero length:** `num_vec`=0. `done` is high in cycle 1, with `wen` never asserted and `arr_en` never asserted.
- **Abort and ignored start:** a second `start` in cycle 5 is ignored. `abort` in cycle 7 gives `busy`=0 and all outputs 0 in cycle 8, with no `done` pulse.
- **Back-to-back:** `start` is accepted in cycle 16, right after `done` in cycle 15. The second run reproduces the nominal waveform offset by 16 cycles.
